// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic datapaths.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Bits needed for a counter that walks 0..w-1 (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_sub_fs_bit.sv
// One-bit full subtractor: d = x - y - bin, bout = borrow out.
module fs_bit (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   // Difference and borrow of a single bit position.
   always_comb begin
      d    = x ^ y ^ bin;
      bout = (~x & y) | (~(x ^ y) & bin);
   end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor, D = A - B - b_in, one bit per clock, LSB first.
// Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
module serial_sub
   import serial_arith_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
  ,output logic             ovf
`endif
);

   localparam int unsigned CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-2:0] r_q;
   logic [CW-1:0]    cnt_q;
   logic             brw_q;
   logic [WIDTH-1:0] d_q;
   logic             bout_q;
   logic             accept, last;
   logic             diff_bit, brw_d;
   logic [WIDTH-1:0] r_next;

   assign accept = start & (state_q != RUN);
   assign last   = (state_q == RUN) && (cnt_q == LAST);

   fs_bit u_fs (
      .x    (a_q[0]),
      .y    (b_q[0]),
      .bin  (brw_q),
      .d    (diff_bit),
      .bout (brw_d)
   );

   // Newest difference bit enters at the top; the bottom bit falls off.
   assign r_next = {diff_bit, r_q};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; DONE accepts a new start just like IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (last)   state_d = DONE;
         DONE:    state_d = accept ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Status outputs decoded from the state register only.
   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
   end

   // Operand capture, serial shifting and result commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         r_q    <= '0;
         cnt_q  <= '0;
         brw_q  <= 1'b0;
         d_q    <= '0;
         bout_q <= 1'b0;
      end else if (state_q == RUN) begin
         a_q   <= a_q >> 1;
         b_q   <= b_q >> 1;
         r_q   <= r_next[WIDTH-1:1];
         brw_q <= brw_d;
         cnt_q <= cnt_q + 1'b1;
         if (last) begin
            d_q    <= r_next;
            bout_q <= brw_d;
         end
      end else if (accept) begin
         a_q   <= a;
         b_q   <= b;
         brw_q <= b_in;
         cnt_q <= '0;
      end
   end

   assign d     = d_q;
   assign b_out = bout_q;

`ifdef SERIAL_SUB_OVF_EN
   logic ovf_q;

   // Signed overflow: borrow into the MSB differs from borrow out of it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    ovf_q <= 1'b0;
      else if (last) ovf_q <= brw_q ^ brw_d;
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Directed-vector bench for serial_sub (WIDTH=4).
module tb_serial_sub;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         b_in = 1'b0;
   logic         busy, done, b_out;
   logic [W-1:0] d;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   serial_sub #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .b_in  (b_in),
      .busy  (busy),
      .done  (done),
      .d     (d),
      .b_out (b_out)
`ifdef SERIAL_SUB_OVF_EN
     ,.ovf   (ovf)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Single operation: start accepted at edge E0, done after edge E4.
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                         input logic [W-1:0] ed, input logic eb, input string tag);
      @(negedge clk);
      a = av; b = bv; b_in = bi; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = ~av; b = ~bv; b_in = ~bi;
      chk({tag, " busy@E0"}, {31'd0, busy}, 32'd1);
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         if (i < 4) chk({tag, " done early"}, {31'd0, done}, 32'd0);
      end
      chk({tag, " done"}, {31'd0, done}, 32'd1);
      chk({tag, " busy@done"}, {31'd0, busy}, 32'd0);
      chk({tag, " d"}, {28'd0, d}, {28'd0, ed});
      chk({tag, " b_out"}, {31'd0, b_out}, {31'd0, eb});
      @(posedge clk); #1;
      chk({tag, " done drop"}, {31'd0, done}, 32'd0);
      chk({tag, " d hold"}, {28'd0, d}, {28'd0, ed});
   endtask

   initial begin
      int unsigned pulses;
      #12;
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      chk("reset d", {28'd0, d}, 32'd0);
      chk("reset b_out", {31'd0, b_out}, 32'd0);
      rst_n = 1'b1;

      run_op(4'd5, 4'd3, 1'b0, 4'd2, 1'b0, "5-3");
      run_op(4'd3, 4'd5, 1'b0, 4'hE, 1'b1, "3-5");
      run_op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, "0-0-1");

      // Start re-asserted during RUN must be ignored.
      @(negedge clk);
      a = 4'd7; b = 4'd2; b_in = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      pulses = 0;
      for (int i = 1; i <= 10; i++) begin
         if (i == 1) begin a = 4'd9; b = 4'd1; start = 1'b1; end
         if (i == 3) start = 1'b0;
         @(posedge clk); #1;
         if (done) pulses++;
         if (i == 4) chk("7-2 d", {28'd0, d}, 32'd5);
         if (i == 4) chk("7-2 b_out", {31'd0, b_out}, 32'd0);
      end
      chk("ignored start pulses", pulses, 32'd1);
      chk("ignored start idle", {31'd0, busy}, 32'd0);

      // Asynchronous reset two cycles into RUN.
      @(negedge clk);
      a = 4'd10; b = 4'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); @(posedge clk); #3;
      rst_n = 1'b0; #1;
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort done", {31'd0, done}, 32'd0);
      chk("abort d", {28'd0, d}, 32'd0);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      rst_n = 1'b1;
      chk("abort no done", pulses, 32'd0);
      run_op(4'd12, 4'd4, 1'b0, 4'd8, 1'b0, "12-4");

      // Start held high: one op per five cycles.
      @(negedge clk);
      a = 4'd15; b = 4'd15; b_in = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      for (int i = 1; i <= 15; i++) begin
         @(posedge clk); #1;
         chk("b2b done", {31'd0, done}, {31'd0, (i % 5) == 4});
         if ((i % 5) == 4) begin
            chk("b2b d", {28'd0, d}, 32'd0);
            chk("b2b b_out", {31'd0, b_out}, 32'd0);
         end
      end
      start = 1'b0;
      repeat (6) @(posedge clk);

`ifdef SERIAL_SUB_OVF_EN
      run_op(4'd8, 4'd1, 1'b0, 4'd7, 1'b0, "8-1");
      chk("8-1 ovf", {31'd0, ovf}, 32'd1);
      run_op(4'd7, 4'd1, 1'b0, 4'd6, 1'b0, "7-1");
      chk("7-1 ovf", {31'd0, ovf}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial subtractor. Computes D = A - B - borrow_in over WIDTH operand bits, one bit per clock, LSB first.
- Built from a single one-bit full-subtractor cell and a borrow flip-flop.
- It is the inverse-operation counterpart of the team's ripple-carry adder datapath, for area-constrained arithmetic paths that can tolerate multi-cycle latency.
- Uses a start/busy/done handshake.

Parameters:
- WIDTH, 4, operand and result width in bits (>= 2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a subtraction; sampled only when busy=0.
- a  input  WIDTH  minuend, captured on the accepted start.
- b  input  WIDTH  subtrahend, captured on the accepted start.
- b_in  input  1  borrow-in, captured on the accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; d/b_out are valid from this cycle on.
- d  output  WIDTH  difference (A - B - b_in) mod 2^WIDTH.
- b_out  output  1  borrow-out; 1 when A < B + b_in (unsigned).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, d=0, b_out=0.
  - Internal shift registers, bit counter and borrow FF cleared.
  - Takes effect immediately, including mid-operation. The aborted operation produces no done.
- FSM states:
  - IDLE: busy=0. On start=1 at an edge: latch a, b into shift registers, borrow FF<=b_in, cnt<=0, go to RUN.
  - RUN: busy=1. Each edge:
    - diff bit = a0 ^ b0 ^ brw; next brw = (~a0 & b0) | (~(a0 ^ b0) & brw).
    - Diff bit shifts into the result register MSB; a/b registers shift right; cnt++.
    - On the edge where cnt==WIDTH-1: go to DONE, load d from the completed result, b_out<=final borrow, done<=1.
  - DONE: busy=0, done=1 for exactly this cycle. Next edge goes to IDLE, done<=0.
  - A start sampled in DONE is accepted exactly as in IDLE: transitions directly to RUN, so back-to-back ops are possible.
- Latency: start sampled at edge E0 -> done=1 after edge E(WIDTH). For WIDTH=4, done rises 4 cycles after the start edge. Throughput is one op per WIDTH+1 cycles max.
- start while busy=1 (RUN): ignored, with no effect on the operation in flight.
- a, b, b_in may change freely after the accepting edge.
- d and b_out change only on the done edge (or on reset). Values hold until the next completion.
- All outputs are registered; no combinational input-to-output path.
- Wrap-around: the result is modulo 2^WIDTH; the borrow is reported only through b_out.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- When defined:
  - Extra output port ovf (1 bit): two's-complement signed overflow, = a[W-1]^b[W-1] & (a[W-1]^d[W-1]) for the captured operands including borrow effect. Equivalently, the borrow into the MSB XOR the borrow out of the MSB.
  - ovf updates on the done edge and holds.
  - Reset value 0.
- When undefined: no ovf port and no associated logic.

Decomposition:
- Shared package serial_arith_pkg:
  - state enum typedef (IDLE, RUN, DONE).
  - Counter-width constant function clog2-based on WIDTH.
- Sub-module fs_bit (combinational one-bit full subtractor: x, y, bin -> d, bout), instanced once. It is the subtraction analogue of the existing one-bit full-adder cell.

Test Plan:
- WIDTH=4, a=5, b=3, b_in=0, start pulse -> busy for 4 cycles; done pulse 4 cycles after start; d=2, b_out=0.
- a=3, b=5, b_in=0 -> d=4'hE, b_out=1. Then a=0, b=0, b_in=1 -> d=4'hF, b_out=1.
- start re-asserted with a=9, b=1 during RUN of a=7, b=2 -> ignored; d=5 for the first op, and only one done pulse.
- rst_n pulled low 2 cycles into RUN -> busy=0, done=0, d=0 immediately. After release, a new op a=12, b=4 -> d=8, b_out=0.
- start held high continuously with a=15, b=15 -> done every 5 cycles, d=0, b_out=0 each time. No lost or extra done pulses.
- SERIAL_SUB_OVF_EN defined:
  - a=8, b=1 -> d=7, ovf=1.
  - a=7, b=1 -> d=6, ovf=0.
  - Build without the macro compiles with no ovf port.
